// File: rtl/block_code_frame_assembler_pkg.sv
// rtl/block_code_frame_assembler_pkg.sv - shared constants and types for the (20,A) frame assembler
package block_code_pkg;

    localparam int NUM_SYMBOLS_DEF = 20;
    localparam int DATA_WIDTH_DEF  = 4;
    localparam int MAX_CODE_LEN    = 13;
    localparam int CODE_LEN_W      = 8;

    localparam int TUSER_LEN_ERR = 0;
    localparam int TUSER_FRM_ERR = 1;

    typedef logic [DATA_WIDTH_DEF-1:0] symbol_t;

    function automatic logic code_len_illegal(input logic [CODE_LEN_W-1:0] len,
                                              input int max_len);
        return (len == '0) || (len > CODE_LEN_W'(max_len));
    endfunction

endpackage

// File: rtl/block_code_frame_assembler_bank.sv
// rtl/block_code_frame_assembler_bank.sv - one ping-pong half: symbol array, latched length, tuser, full flag
module block_code_frame_bank
    import block_code_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int NUM_SYMBOLS = NUM_SYMBOLS_DEF,
    parameter int IDX_W       = $clog2(NUM_SYMBOLS)
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [CODE_LEN_W-1:0]             code_length,
    input  logic                              len_err,
    input  logic                              set_full,
    input  logic                              frm_err,
    input  logic                              clr_full,
    output logic [NUM_SYMBOLS*DATA_WIDTH-1:0] frame,
    output logic [CODE_LEN_W-1:0]             len,
    output logic [1:0]                        tuser,
    output logic                              full
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame <= '0;
            len   <= '0;
            tuser <= '0;
            full  <= 1'b0;
        end else begin
            if (wr_en) begin
                frame[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
                if (wr_idx == '0) begin
                    len                  <= code_length;
                    tuser[TUSER_LEN_ERR] <= len_err;
                end
            end
            // Framing status is only final once the last symbol lands.
            if (set_full) begin
                full                 <= 1'b1;
                tuser[TUSER_FRM_ERR] <= frm_err;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/block_code_frame_assembler.sv
// rtl/block_code_frame_assembler.sv - serial soft symbols to ping-pong parallel frames; BLOCK_CODE_TLAST_CHECK_EN adds tlast framing check
module block_code_frame_assembler #(
    parameter int DATA_WIDTH   = 4,
    parameter int NUM_SYMBOLS  = 20,
    parameter int MAX_CODE_LEN = 13
) (
    input  logic                              clk,
    input  logic                              s_axis_aresetn,
    input  logic [7:0]                        code_length,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic                              s_axis_tvalid,
`ifdef BLOCK_CODE_TLAST_CHECK_EN
    input  logic                              s_axis_tlast,
`endif
    output logic                              s_axis_tready,
    output logic [NUM_SYMBOLS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [7:0]                        m_code_length,
    output logic [1:0]                        m_axis_tuser
);
    import block_code_pkg::*;

    localparam int IDX_W   = $clog2(NUM_SYMBOLS);
    localparam int FRAME_W = NUM_SYMBOLS * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYMBOLS - 1);

    logic                  run;
    logic [IDX_W-1:0]      wr_cnt;
    logic                  wr_sel;
    logic                  rd_sel;
    logic [1:0]            full;
    logic [FRAME_W-1:0]    bank_data [2];
    logic [CODE_LEN_W-1:0] bank_len  [2];
    logic [1:0]            bank_user [2];
    logic                  accept;
    logic                  complete;
    logic                  discard;
    logic                  frm_err;
    logic                  len_err;
    logic                  deliver;

    assign s_axis_tready = run && !full[wr_sel];
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign complete      = accept && (wr_cnt == LAST_IDX);
    assign m_axis_tvalid = full[rd_sel];
    assign deliver       = m_axis_tvalid && m_axis_tready;
    assign len_err       = code_len_illegal(code_length, MAX_CODE_LEN);

`ifdef BLOCK_CODE_TLAST_CHECK_EN
    logic err_pend;

    assign discard = accept && s_axis_tlast && (wr_cnt != LAST_IDX);
    assign frm_err = err_pend || !s_axis_tlast;

    // An early tlast poisons the next frame that actually completes.
    always_ff @(posedge clk) begin
        if (!s_axis_aresetn) begin
            err_pend <= 1'b0;
        end else if (discard) begin
            err_pend <= 1'b1;
        end else if (complete) begin
            err_pend <= 1'b0;
        end
    end
`else
    assign discard = 1'b0;
    assign frm_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!s_axis_aresetn) begin
            run    <= 1'b0;
            wr_cnt <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            run <= 1'b1;
            if (complete || discard) begin
                wr_cnt <= '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (complete) begin
                wr_sel <= ~wr_sel;
            end
            if (deliver) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        block_code_frame_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_SYMBOLS(NUM_SYMBOLS),
            .IDX_W      (IDX_W)
        ) u_bank (
            .clk        (clk),
            .resetn     (s_axis_aresetn),
            .wr_en      (accept && (wr_sel == 1'(b))),
            .wr_idx     (wr_cnt),
            .wr_data    (s_axis_tdata),
            .code_length(code_length),
            .len_err    (len_err),
            .set_full   (complete && (wr_sel == 1'(b))),
            .frm_err    (frm_err),
            .clr_full   (deliver && (rd_sel == 1'(b))),
            .frame      (bank_data[b]),
            .len        (bank_len[b]),
            .tuser      (bank_user[b]),
            .full       (full[b])
        );
    end

    assign m_axis_tdata  = bank_data[rd_sel];
    assign m_code_length = bank_len[rd_sel];
    assign m_axis_tuser  = bank_user[rd_sel];

endmodule
